// File: rtl/cloud_scheduler.sv
// Background cloud scheduler: three horizontally scrolling cloud slots with
// LFSR-jittered spawn height and spawn interval, gated by a run/freeze FSM.
module cloud_scheduler #(
  parameter int          SCREEN_W  = 640,
  parameter int          CLOUD_W   = 80,
  parameter int          HVEL      = 2,
  parameter int          V_BASE    = 40,
  parameter int          SPAWN_MIN = 60,
  parameter logic [5:0]  RAND_MASK = 6'h3F,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        game_over,
  output logic [29:0] cloud_h,
  output logic [29:0] cloud_v,
  output logic [2:0]  cloud_active,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  localparam logic [9:0] SPAWN_H     = 10'(SCREEN_W + CLOUD_W);
  localparam logic [9:0] HVEL_W      = 10'(HVEL);
  localparam logic [9:0] V_BASE_W    = 10'(V_BASE);
  localparam logic [7:0] SPAWN_MIN_W = 8'(SPAWN_MIN);

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [29:0] h_d, v_d;
  logic [2:0]  act_d;
  logic        do_clear, do_tick;
  logic [2:0]  free, spawn_sel;
  logic [5:0]  jitter;
  logic        feedback;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)                             state_d = RUN;
    else if (game_over && state_q == RUN)  state_d = FROZEN;
  end

  // A freeze request wins over a frame tick arriving in the same cycle.
  always_comb begin
    do_clear = start;
    do_tick  = frame_tick && !start && !game_over && (state_q == RUN);
  end

  assign free      = ~cloud_active;
  assign spawn_sel = free & ~(free - 3'd1);
  assign jitter    = lfsr_q[5:0] & RAND_MASK;
  assign feedback  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // NOTE: every variable gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    h_d     = cloud_h;
    v_d     = cloud_v;
    act_d   = cloud_active;
    timer_d = timer_q;
    lfsr_d  = lfsr_q;
    if (do_clear) begin
      h_d     = '0;
      v_d     = '0;
      act_d   = '0;
      timer_d = 8'd1;
    end else if (do_tick) begin
      for (int i = 0; i < 3; i++) begin
        if (cloud_active[i]) begin
          if (cloud_h[10*i +: 10] <= HVEL_W) begin
            act_d[i]        = 1'b0;
            h_d[10*i +: 10] = '0;
          end else begin
            h_d[10*i +: 10] = cloud_h[10*i +: 10] - HVEL_W;
          end
        end
      end
      // Free slots are judged before retirement, so a retiring slot waits a tick.
      if (timer_q > 8'd1) begin
        timer_d = timer_q - 8'd1;
      end else if (|free) begin
        for (int i = 0; i < 3; i++) begin
          if (spawn_sel[i]) begin
            act_d[i]        = 1'b1;
            h_d[10*i +: 10] = SPAWN_H;
            v_d[10*i +: 10] = V_BASE_W + {4'b0, jitter};
          end
        end
        timer_d = SPAWN_MIN_W + {2'b0, jitter};
      end else begin
        timer_d = 8'd1;
      end
      lfsr_d = {lfsr_q[14:0], feedback};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cloud_h      <= '0;
      cloud_v      <= '0;
      cloud_active <= '0;
      timer_q      <= '0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      cloud_h      <= h_d;
      cloud_v      <= v_d;
      cloud_active <= act_d;
      timer_q      <= timer_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cloud_scheduler.sv
// Bench for cloud_scheduler: two instances (default and fast-spawn configs)
// checked every cycle against a behavioural model, plus literal expectations.
module tb_cloud_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ft[2], st[2], go[2];
  logic [29:0] o_h[2], o_v[2];
  logic [2:0]  o_act[2];
  logic [1:0]  o_st[2];

  int tests = 0;
  int fails = 0;
  int printed = 0;

  always #5 clk = ~clk;

  cloud_scheduler dut_a (
    .clk(clk), .rst(rst), .frame_tick(ft[0]), .start(st[0]), .game_over(go[0]),
    .cloud_h(o_h[0]), .cloud_v(o_v[0]), .cloud_active(o_act[0]), .state(o_st[0])
  );

  cloud_scheduler #(.HVEL(40), .SPAWN_MIN(2), .RAND_MASK(6'h00)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(ft[1]), .start(st[1]), .game_over(go[1]),
    .cloud_h(o_h[1]), .cloud_v(o_v[1]), .cloud_active(o_act[1]), .state(o_st[1])
  );

  // Behavioural model: one record per instance, plain integer arithmetic.
  int        c_hvel[2] = '{2, 40};
  int        c_smin[2] = '{60, 2};
  int        c_mask[2] = '{63, 0};
  int        m_st[2];
  int        m_h[2][3];
  int        m_v[2][3];
  bit        m_act[2][3];
  int        m_timer[2];
  bit [15:0] m_lfsr[2];

  task automatic model_reset(input int d);
    m_st[d] = 0;
    m_timer[d] = 0;
    m_lfsr[d] = 16'hACE1;
    for (int i = 0; i < 3; i++) begin
      m_h[d][i] = 0; m_v[d][i] = 0; m_act[d][i] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int slot;
    int jit;
    bit fb;
    if (st[d]) begin
      m_st[d] = 1;
      m_timer[d] = 1;
      for (int i = 0; i < 3; i++) begin
        m_h[d][i] = 0; m_v[d][i] = 0; m_act[d][i] = 0;
      end
    end else if (go[d] && m_st[d] == 1) begin
      m_st[d] = 2;
    end else if (ft[d] && m_st[d] == 1) begin
      slot = -1;
      for (int i = 2; i >= 0; i--) if (!m_act[d][i]) slot = i;
      for (int i = 0; i < 3; i++) begin
        if (m_act[d][i]) begin
          if (m_h[d][i] <= c_hvel[d]) begin
            m_act[d][i] = 0; m_h[d][i] = 0;
          end else begin
            m_h[d][i] = m_h[d][i] - c_hvel[d];
          end
        end
      end
      jit = (m_lfsr[d] % 64) & c_mask[d];
      if (m_timer[d] > 1) begin
        m_timer[d] = m_timer[d] - 1;
      end else if (slot >= 0) begin
        m_act[d][slot] = 1;
        m_h[d][slot] = 640 + 80;
        m_v[d][slot] = 40 + jit;
        m_timer[d] = c_smin[d] + jit;
      end else begin
        m_timer[d] = 1;
      end
      fb = m_lfsr[d][15] ^ m_lfsr[d][13] ^ m_lfsr[d][12] ^ m_lfsr[d][10];
      m_lfsr[d] = {m_lfsr[d][14:0], fb};
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [29:0] e_h, e_v;
    logic [2:0]  e_a;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 3; i++) begin
          e_h[10*i +: 10] = 10'(m_h[d][i]);
          e_v[10*i +: 10] = 10'(m_v[d][i]);
          e_a[i] = m_act[d][i];
        end
        tests++;
        if (o_h[d] !== e_h || o_v[d] !== e_v || o_act[d] !== e_a ||
            o_st[d] !== 2'(m_st[d])) begin
          fails++;
          if (printed < 20) begin
            printed++;
            $display("FAIL model_cmp[%0d] t=%0t got h=%h v=%h act=%b st=%0d want h=%h v=%h act=%b st=%0d",
                     d, $time, o_h[d], o_v[d], o_act[d], o_st[d], e_h, e_v, e_a, m_st[d]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      ft[d] = 1'b1;
      cyc();
    end
    ft[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ft[d] = 1'b0; st[d] = 1'b0; go[d] = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("reset_state", 32'(o_st[0]), 0);
    check("reset_active", 32'(o_act[0]), 0);
    #11;
    rst = 1'b0;
    cyc();

    // Frame ticks in IDLE change nothing, including the LFSR (seen via v below).
    ticks(0, 5);
    check("idle_state", 32'(o_st[0]), 0);
    check("idle_h", 32'(o_h[0]), 0);
    check("idle_active", 32'(o_act[0]), 0);

    st[0] = 1'b1; cyc(); st[0] = 1'b0;
    check("start_state", 32'(o_st[0]), 1);
    check("start_active", 32'(o_act[0]), 0);

    ticks(0, 1);
    check("spawn_active", 32'(o_act[0]), 1);
    check("spawn_h", 32'(o_h[0][9:0]), 720);
    check("spawn_v", 32'(o_v[0][9:0]), 73);

    ticks(0, 92);
    check("timer93_not_yet", 32'(o_act[0]), 1);
    check("scroll_h", 32'(o_h[0][9:0]), 536);
    ticks(0, 1);
    check("timer93_spawn", 32'(o_act[0]), 3);

    ticks(0, 266);
    check("edge_h2", 32'(o_h[0][9:0]), 2);
    check("edge_act", 32'(o_act[0][0]), 1);
    ticks(0, 1);
    check("retire_act", 32'(o_act[0][0]), 0);
    check("retire_h", 32'(o_h[0][9:0]), 0);

    // Fast-spawn configuration: fill, saturate, retire, deferred respawn.
    st[1] = 1'b1; cyc(); st[1] = 1'b0;
    ticks(1, 7);
    check("fill_act", 32'(o_act[1]), 7);
    check("fill_h0", 32'(o_h[1][9:0]), 480);
    ticks(1, 11);
    check("full_h0", 32'(o_h[1][9:0]), 40);
    ticks(1, 1);
    check("full_retire_act", 32'(o_act[1]), 6);
    check("full_h1", 32'(o_h[1][19:10]), 80);
    check("full_h2", 32'(o_h[1][29:20]), 160);
    ticks(1, 1);
    check("respawn_act", 32'(o_act[1]), 7);
    check("respawn_h0", 32'(o_h[1][9:0]), 720);
    check("respawn_v0", 32'(o_v[1][9:0]), 40);

    // Freeze, ignored ticks, then start beating a simultaneous game_over.
    go[0] = 1'b1; cyc(); go[0] = 1'b0;
    check("frozen_state", 32'(o_st[0]), 2);
    ticks(0, 10);
    check("frozen_hold_state", 32'(o_st[0]), 2);
    st[0] = 1'b1; go[0] = 1'b1; cyc(); st[0] = 1'b0; go[0] = 1'b0;
    check("start_prio_state", 32'(o_st[0]), 1);
    check("start_prio_active", 32'(o_act[0]), 0);
    check("start_prio_h", 32'(o_h[0]), 0);

    // Asynchronous reset mid-run takes effect without a clock edge.
    ticks(0, 3);
    rst = 1'b1;
    #1;
    check("async_state", 32'(o_st[0]), 0);
    check("async_active", 32'(o_act[0]), 0);
    check("async_h", 32'(o_h[0]), 0);
    check("async_v", 32'(o_v[0]), 0);
    check("async_state_b", 32'(o_st[1]), 0);
    #1;
    rst = 1'b0;
    cyc();

    // Randomized traffic on both instances.
    st[0] = 1'b1; st[1] = 1'b1; cyc();
    for (int n = 0; n < 4000; n++) begin
      for (int d = 0; d < 2; d++) begin
        go[d] = ($urandom % 150) == 0;
        st[d] = ($urandom % 200) == 0;
        ft[d] = !go[d] && ($urandom % 2 == 0);
      end
      cyc();
    end
    for (int d = 0; d < 2; d++) begin
      ft[d] = 1'b0; st[d] = 1'b0; go[d] = 1'b0;
    end
    cyc();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
